// File: rtl/ps2_host_intf.sv
// PS/2 host port: filtered clock sampling, framed byte receive into a first-word
// fall-through FIFO, bit watchdog. Define PS2_TX_EN to build the host-to-device transmitter.
module ps2_host_intf #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int INHIBIT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DATA_I,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_ERROR,
  output logic       RX_OVERFLOW,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WRITE,
  output logic       TX_BUSY,
  output logic       TX_ACK,
  output logic       TX_ERROR
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {RX_IDLE, RX_BITS} rx_state_e;

  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  clk_f_q, clk_f_d;
  logic                  data_q;
  logic                  fall_edge;
  rx_state_e             rx_state_q, rx_state_d;
  logic [3:0]            rx_cnt_q, rx_cnt_d;
  logic [8:0]            rx_sr_q, rx_sr_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  wd_active, timeout;
  logic                  rx_err_q, rx_err_d;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic                  frame_ok, push, pop, full, empty;
  logic                  tx_busy, tx_wd_active;

  // Clock is only trusted once FILTER_LEN consecutive samples agree
  always_comb begin
    filt_d    = {filt_q[FILTER_LEN-2:0], PS2_CLK_I};
    clk_f_d   = clk_f_q;
    if (&filt_q)       clk_f_d = 1'b1;
    else if (~|filt_q) clk_f_d = 1'b0;
    fall_edge = clk_f_q & ~|filt_q;
  end

  assign wd_active = (rx_state_q == RX_BITS) | tx_wd_active;
  assign timeout   = wd_active & ~fall_edge & (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  assign wd_d      = (~wd_active | fall_edge | timeout) ? '0 : wd_q + WDW'(1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sr_d    = rx_sr_q;
    frame_ok   = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (fall_edge && !data_q) begin
          rx_state_d = RX_BITS;
          rx_cnt_d   = 4'd0;
        end
      end
      RX_BITS: begin
        if (timeout) begin
          rx_state_d = RX_IDLE;
          rx_err_d   = 1'b1;
        end else if (fall_edge) begin
          if (rx_cnt_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            // Odd parity: data plus parity bit must hold an odd number of ones
            if (data_q && (^rx_sr_q)) frame_ok = 1'b1;
            else                      rx_err_d = 1'b1;
          end else begin
            rx_sr_d  = {data_q, rx_sr_q[8:1]};
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (tx_busy) begin
      rx_state_d = RX_IDLE;
      frame_ok   = 1'b0;
      rx_err_d   = 1'b0;
    end
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign RX_VALID = ~empty;
  assign RX_DATA  = RX_VALID ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  assign pop      = RX_VALID & RX_READY;
  assign push     = frame_ok & (~full | pop);
  assign ovf_d    = frame_ok & full & ~pop;
  assign wptr_d   = wptr_q + PW'(push);
  assign rptr_d   = rptr_q + PW'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_sr_q[7:0];
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      filt_q     <= '1;
      clk_f_q    <= 1'b1;
      data_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      wd_q       <= '0;
      rx_err_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      filt_q     <= filt_d;
      clk_f_q    <= clk_f_d;
      data_q     <= PS2_DATA_I;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      wd_q       <= wd_d;
      rx_err_q   <= rx_err_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  assign RX_ERROR    = rx_err_q;
  assign RX_OVERFLOW = ovf_q;

`ifdef PS2_TX_EN
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_INHIBIT, TX_START, TX_BITS, TX_ACKW} tx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [9:0]    tx_sr_q, tx_sr_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [IW-1:0] inh_q, inh_d;
  logic          tx_ack_q, tx_ack_d, tx_err_q, tx_err_d;
  logic          clk_oe, data_oe;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    inh_d      = inh_q;
    tx_ack_d   = 1'b0;
    tx_err_d   = 1'b0;
    clk_oe     = 1'b0;
    data_oe    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (TX_WRITE) begin
          tx_state_d = TX_INHIBIT;
          inh_d      = '0;
          tx_sr_d    = {1'b1, ~^TX_DATA, TX_DATA};
        end
      end
      TX_INHIBIT: begin
        clk_oe = 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) tx_state_d = TX_START;
        else                                  inh_d = inh_q + IW'(1);
      end
      TX_START: begin
        data_oe = 1'b1;
        if (timeout) begin
          tx_state_d = TX_IDLE;
          tx_err_d   = 1'b1;
        end else if (fall_edge) begin
          tx_state_d = TX_BITS;
          tx_cnt_d   = 4'd0;
        end
      end
      TX_BITS: begin
        // tx_sr_q[0] is the bit currently on the wire; a 1 is sent by releasing the line
        data_oe = ~tx_sr_q[0];
        if (timeout) begin
          tx_state_d = TX_IDLE;
          tx_err_d   = 1'b1;
        end else if (fall_edge) begin
          tx_sr_d = {1'b1, tx_sr_q[9:1]};
          if (tx_cnt_q == 4'd8) tx_state_d = TX_ACKW;
          else                  tx_cnt_d = tx_cnt_q + 4'd1;
        end
      end
      TX_ACKW: begin
        if (timeout) begin
          tx_state_d = TX_IDLE;
          tx_err_d   = 1'b1;
        end else if (fall_edge) begin
          tx_state_d = TX_IDLE;
          if (!data_q) tx_ack_d = 1'b1;
          else         tx_err_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      tx_state_q <= TX_IDLE;
      tx_sr_q    <= '1;
      tx_cnt_q   <= '0;
      inh_q      <= '0;
      tx_ack_q   <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      inh_q      <= inh_d;
      tx_ack_q   <= tx_ack_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign tx_wd_active = (tx_state_q == TX_START) | (tx_state_q == TX_BITS) |
                        (tx_state_q == TX_ACKW);
  assign PS2_CLK_OE   = clk_oe;
  assign PS2_DATA_OE  = data_oe;
  assign TX_BUSY      = tx_busy;
  assign TX_ACK       = tx_ack_q;
  assign TX_ERROR     = tx_err_q;
`else
  logic unused_tx;
  assign unused_tx    = ^{TX_DATA, TX_WRITE};
  assign tx_busy      = 1'b0;
  assign tx_wd_active = 1'b0;
  assign PS2_CLK_OE   = 1'b0;
  assign PS2_DATA_OE  = 1'b0;
  assign TX_BUSY      = 1'b0;
  assign TX_ACK       = 1'b0;
  assign TX_ERROR     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_intf.sv
// Directed bench for ps2_host_intf: a PS/2 device model drives framed bytes onto
// wired-AND pins and, when PS2_TX_EN is defined, clocks a host transmission.
module tb_ps2_host_intf;

  localparam int FILTER_LEN = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 400;
  localparam int INHIBIT    = 50;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       PS2_CLK_I, PS2_DATA_I, PS2_CLK_OE, PS2_DATA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_READY, RX_ERROR, RX_OVERFLOW;
  logic [7:0] TX_DATA;
  logic       TX_WRITE, TX_BUSY, TX_ACK, TX_ERROR;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0, ovf_cnt = 0, both_cnt = 0, ack_cnt = 0, txerr_cnt = 0;

  // Open-drain pins: the line is low if either side pulls it
  assign PS2_CLK_I  = dev_clk  & ~PS2_CLK_OE;
  assign PS2_DATA_I = dev_data & ~PS2_DATA_OE;

  always #5 CLK = ~CLK;

  ps2_host_intf #(
    .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT), .INHIBIT_CYCLES(INHIBIT)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .PS2_CLK_I(PS2_CLK_I), .PS2_DATA_I(PS2_DATA_I),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_ERROR(RX_ERROR),
    .RX_OVERFLOW(RX_OVERFLOW), .TX_DATA(TX_DATA), .TX_WRITE(TX_WRITE),
    .TX_BUSY(TX_BUSY), .TX_ACK(TX_ACK), .TX_ERROR(TX_ERROR)
  );

  always @(posedge CLK) begin
    if (nRESET) begin
      if (RX_ERROR)              err_cnt   <= err_cnt + 1;
      if (RX_OVERFLOW)           ovf_cnt   <= ovf_cnt + 1;
      if (RX_ERROR && RX_OVERFLOW) both_cnt <= both_cnt + 1;
      if (TX_ACK)                ack_cnt   <= ack_cnt + 1;
      if (TX_ERROR)              txerr_cnt <= txerr_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic glitch();
    tick(10);
    dev_clk = 1'b0;
    tick(2);
    dev_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_bit(input logic b);
    dev_data = b;
    tick(15);
    dev_clk = 1'b0;
    tick(30);
    dev_clk = 1'b1;
    tick(15);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i]);
      if (i == glitch_at) glitch();
    end
    dev_data = 1'b1;
    tick(2);
  endtask

  task automatic pop_one();
    RX_READY = 1'b1;
    tick(1);
    RX_READY = 1'b0;
  endtask

`ifdef PS2_TX_EN
  task automatic dev_clock_tx(input logic do_ack, output logic [10:0] w);
    w[0] = PS2_DATA_I;
    for (int k = 1; k < 11; k++) begin
      dev_clk = 1'b0;
      tick(30);
      dev_clk = 1'b1;
      tick(15);
      w[k] = PS2_DATA_I;
      tick(15);
    end
    if (do_ack) dev_data = 1'b0;
    tick(5);
    dev_clk = 1'b0;
    tick(30);
    dev_clk = 1'b1;
    tick(15);
    dev_data = 1'b1;
    tick(5);
  endtask

  task automatic start_tx(input logic [7:0] d, output int inh);
    TX_DATA  = d;
    TX_WRITE = 1'b1;
    tick(1);
    TX_WRITE = 1'b0;
    inh = 0;
    while (PS2_CLK_OE && inh < 1000) begin
      inh++;
      tick(1);
    end
  endtask
`endif

  initial begin
    nRESET   = 1'b0;
    RX_READY = 1'b0;
    TX_DATA  = 8'h00;
    TX_WRITE = 1'b0;
    tick(3);
    check("reset_rx_valid", RX_VALID, 0);
    check("reset_rx_data", RX_DATA, 0);
    check("reset_rx_error", RX_ERROR, 0);
    check("reset_overflow", RX_OVERFLOW, 0);
    check("reset_outputs_tx", {TX_BUSY, TX_ACK, TX_ERROR, PS2_CLK_OE, PS2_DATA_OE}, 0);
    nRESET = 1'b1;
    tick(10);

    // Good frame
    send_frame(8'h1C, 1'b0, -1);
    check("good_valid", RX_VALID, 1);
    check("good_data", RX_DATA, 8'h1C);
    check("good_no_error", err_cnt, 0);
    pop_one();
    check("pop_empty", RX_VALID, 0);
    pop_one();
    check("pop_when_empty", RX_VALID, 0);

    // Bad parity
    send_frame(8'h1C, 1'b1, -1);
    check("parity_err_pulse", err_cnt, 1);
    check("parity_no_push", RX_VALID, 0);

    // Overflow on fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, -1);
    check("ovf_pulse", ovf_cnt, 1);
    check("ovf_no_error", err_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_order", RX_DATA, i);
      pop_one();
    end
    check("fifo_drained", RX_VALID, 0);

    // Watchdog: start bit plus three bits, then silence
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    dev_data = 1'b1;
    tick(TIMEOUT + 50);
    check("timeout_err", err_cnt, 2);
    check("timeout_no_push", RX_VALID, 0);
    send_frame(8'hF0, 1'b0, -1);
    check("after_timeout_data", RX_DATA, 8'hF0);
    check("after_timeout_err", err_cnt, 2);
    pop_one();

    // Reset mid-frame discards FIFO and partial frame
    send_frame(8'h33, 1'b0, -1);
    send_bit(1'b0);
    send_bit(1'b1);
    nRESET = 1'b0;
    tick(2);
    nRESET = 1'b1;
    dev_data = 1'b1;
    tick(20);
    check("reset_flush", RX_VALID, 0);

    // Glitches: idle with data low, then mid-frame
    dev_data = 1'b0;
    glitch();
    dev_data = 1'b1;
    tick(20);
    send_frame(8'h5A, 1'b0, 3);
    check("glitch_data", RX_DATA, 8'h5A);
    check("glitch_no_err", err_cnt, 2);
    pop_one();
    check("glitch_single", RX_VALID, 0);

`ifdef PS2_TX_EN
    begin
      int inh;
      logic [10:0] w;
      start_tx(8'hED, inh);
      check("tx_inhibit_len", inh, INHIBIT);
      check("tx_start_oes", {PS2_CLK_OE, PS2_DATA_OE, TX_BUSY}, 3'b011);
      tick(15);
      dev_clock_tx(1'b1, w);
      check("tx_start_bit", w[0], 0);
      check("tx_data_bits", w[8:1], 8'hED);
      check("tx_parity", w[9], 1);
      check("tx_stop", w[10], 1);
      check("tx_ack", ack_cnt, 1);
      check("tx_ack_no_err", txerr_cnt, 0);
      check("tx_done_idle", {TX_BUSY, PS2_CLK_OE, PS2_DATA_OE}, 0);

      start_tx(8'h55, inh);
      tick(15);
      dev_clock_tx(1'b0, w);
      check("tx_nak_data", w[8:1], 8'h55);
      check("tx_nak_err", txerr_cnt, 1);
      check("tx_nak_ack", ack_cnt, 1);
      check("tx_nak_idle", {TX_BUSY, PS2_CLK_OE, PS2_DATA_OE}, 0);
      check("tx_rx_quiet", {err_cnt, 1'b0, RX_VALID}, {32'd2, 1'b0, 1'b0});
    end
`else
    TX_DATA  = 8'hED;
    TX_WRITE = 1'b1;
    tick(1);
    TX_WRITE = 1'b0;
    tick(3);
    check("notx_tied", {TX_BUSY, TX_ACK, TX_ERROR, PS2_CLK_OE, PS2_DATA_OE}, 0);
`endif

    check("err_ovf_exclusive", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
